// File: rtl/axil_regbank_if.sv
// AXI4-Lite bus bundle for axil_regbank: the five handshake channels.
// The master modport drives requests, the slave modport answers them.
interface axil_regbank_if #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 6
);
    logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR;
    logic [2:0]                      S_AXI_AWPROT;
    logic                            S_AXI_AWVALID;
    logic                            S_AXI_AWREADY;
    logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA;
    logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB;
    logic                            S_AXI_WVALID;
    logic                            S_AXI_WREADY;
    logic [1:0]                      S_AXI_BRESP;
    logic                            S_AXI_BVALID;
    logic                            S_AXI_BREADY;
    logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR;
    logic [2:0]                      S_AXI_ARPROT;
    logic                            S_AXI_ARVALID;
    logic                            S_AXI_ARREADY;
    logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA;
    logic [1:0]                      S_AXI_RRESP;
    logic                            S_AXI_RVALID;
    logic                            S_AXI_RREADY;

    modport master (
        output S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
        input  S_AXI_AWREADY,
        output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
        input  S_AXI_WREADY,
        input  S_AXI_BRESP, S_AXI_BVALID,
        output S_AXI_BREADY,
        output S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
        input  S_AXI_ARREADY,
        input  S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
        output S_AXI_RREADY
    );

    modport slave (
        input  S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
        output S_AXI_AWREADY,
        input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
        output S_AXI_WREADY,
        output S_AXI_BRESP, S_AXI_BVALID,
        input  S_AXI_BREADY,
        input  S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
        output S_AXI_ARREADY,
        output S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
        input  S_AXI_RREADY
    );
endinterface

// File: rtl/axil_regbank.sv
// Parametrised AXI4-Lite register bank with read-only hardware-fed entries,
// byte-strobe writes, SLVERR decode and per-register access strobes.
module axil_regbank #(
    parameter int                                    C_S_AXI_DATA_WIDTH = 32,
    parameter int                                    NUM_REGS           = 16,
    parameter int                                    C_S_AXI_ADDR_WIDTH = 6,
    parameter logic [NUM_REGS-1:0]                   RO_MASK            = 'h3,
    parameter logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] RESET_VAL         = '0
) (
    input  logic                                            S_AXI_ACLK,
    input  logic                                            S_AXI_ARESETN,
    axil_regbank_if.slave                                   s_axi,
    output logic [NUM_REGS-1:0][C_S_AXI_DATA_WIDTH-1:0]     slv_reg,
    input  logic [NUM_REGS-1:0][C_S_AXI_DATA_WIDTH-1:0]     slv_read,
    output logic [NUM_REGS-1:0]                             wr_stb,
    output logic [NUM_REGS-1:0]                             rd_stb
);
    localparam int DW  = C_S_AXI_DATA_WIDTH;
    localparam int AW  = C_S_AXI_ADDR_WIDTH;
    localparam int SW  = DW / 8;
    localparam int OFF = $clog2(SW);
    localparam int IW  = AW - OFF;
    localparam int LW  = $clog2(NUM_REGS);

    logic [NUM_REGS-1:0][DW-1:0] regs_q, regs_d;
    logic                aw_full_q, aw_full_d;
    logic [IW-1:0]       aw_idx_q, aw_idx_d;
    logic                w_full_q, w_full_d;
    logic [DW-1:0]       w_data_q, w_data_d;
    logic [SW-1:0]       w_strb_q, w_strb_d;
    logic                bvalid_q, bvalid_d;
    logic [1:0]          bresp_q, bresp_d;
    logic                rvalid_q, rvalid_d;
    logic [DW-1:0]       rdata_q, rdata_d;
    logic [1:0]          rresp_q, rresp_d;
    logic [NUM_REGS-1:0] wr_stb_q, wr_stb_d;
    logic [NUM_REGS-1:0] rd_stb_q, rd_stb_d;

    logic          aw_hs, w_hs, ar_hs, commit;
    logic [IW-1:0] ar_idx;
    logic [LW-1:0] w_li, r_li;
    logic          w_oor, r_oor;

    assign s_axi.S_AXI_AWREADY = S_AXI_ARESETN & ~aw_full_q;
    assign s_axi.S_AXI_WREADY  = S_AXI_ARESETN & ~w_full_q;
    assign s_axi.S_AXI_ARREADY = S_AXI_ARESETN & ~rvalid_q;
    assign s_axi.S_AXI_BVALID  = bvalid_q;
    assign s_axi.S_AXI_BRESP   = bresp_q;
    assign s_axi.S_AXI_RVALID  = rvalid_q;
    assign s_axi.S_AXI_RDATA   = rdata_q;
    assign s_axi.S_AXI_RRESP   = rresp_q;
    assign slv_reg = regs_q;
    assign wr_stb  = wr_stb_q;
    assign rd_stb  = rd_stb_q;

    assign aw_hs  = s_axi.S_AXI_AWVALID & s_axi.S_AXI_AWREADY;
    assign w_hs   = s_axi.S_AXI_WVALID & s_axi.S_AXI_WREADY;
    assign ar_hs  = s_axi.S_AXI_ARVALID & s_axi.S_AXI_ARREADY;
    assign commit = aw_full_q & w_full_q & (~bvalid_q | s_axi.S_AXI_BREADY);

    // Indices wider than the bank are decoded as SLVERR; the low bits select the entry.
    assign ar_idx = s_axi.S_AXI_ARADDR[AW-1:OFF];
    assign w_li   = aw_idx_q[LW-1:0];
    assign r_li   = ar_idx[LW-1:0];
    assign w_oor  = 32'(aw_idx_q) >= 32'(NUM_REGS);
    assign r_oor  = 32'(ar_idx) >= 32'(NUM_REGS);

    always_comb begin
        regs_d    = regs_q;
        aw_full_d = aw_full_q;
        aw_idx_d  = aw_idx_q;
        w_full_d  = w_full_q;
        w_data_d  = w_data_q;
        w_strb_d  = w_strb_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        wr_stb_d  = '0;
        if (bvalid_q && s_axi.S_AXI_BREADY) bvalid_d = 1'b0;
        if (commit) begin
            aw_full_d = 1'b0;
            w_full_d  = 1'b0;
            bvalid_d  = 1'b1;
            if (w_oor || RO_MASK[w_li]) begin
                bresp_d = 2'b10;
            end else begin
                bresp_d        = 2'b00;
                wr_stb_d[w_li] = 1'b1;
                for (int b = 0; b < SW; b++)
                    if (w_strb_q[b]) regs_d[w_li][b*8 +: 8] = w_data_q[b*8 +: 8];
            end
        end
        // Holding registers only accept while empty, so these never overlap a commit.
        if (aw_hs) begin
            aw_full_d = 1'b1;
            aw_idx_d  = s_axi.S_AXI_AWADDR[AW-1:OFF];
        end
        if (w_hs) begin
            w_full_d = 1'b1;
            w_data_d = s_axi.S_AXI_WDATA;
            w_strb_d = s_axi.S_AXI_WSTRB;
        end
    end

    always_comb begin
        rvalid_d = rvalid_q;
        rdata_d  = rdata_q;
        rresp_d  = rresp_q;
        rd_stb_d = '0;
        if (rvalid_q && s_axi.S_AXI_RREADY) rvalid_d = 1'b0;
        if (ar_hs) begin
            rvalid_d = 1'b1;
            if (r_oor) begin
                rdata_d = '0;
                rresp_d = 2'b10;
            end else begin
                rresp_d        = 2'b00;
                rd_stb_d[r_li] = 1'b1;
                rdata_d        = RO_MASK[r_li] ? slv_read[r_li] : regs_q[r_li];
            end
        end
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            regs_q    <= RESET_VAL;
            aw_full_q <= 1'b0;
            aw_idx_q  <= '0;
            w_full_q  <= 1'b0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            bvalid_q  <= 1'b0;
            bresp_q   <= 2'b00;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= 2'b00;
            wr_stb_q  <= '0;
            rd_stb_q  <= '0;
        end else begin
            regs_q    <= regs_d;
            aw_full_q <= aw_full_d;
            aw_idx_q  <= aw_idx_d;
            w_full_q  <= w_full_d;
            w_data_q  <= w_data_d;
            w_strb_q  <= w_strb_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
            wr_stb_q  <= wr_stb_d;
            rd_stb_q  <= rd_stb_d;
        end
    end
endmodule

// File: tb/tb_axil_regbank.sv
// Randomized AXI4-Lite traffic against a word-array model of the register bank,
// plus directed reset, stall, collision and error-decode scenarios.
module tb_axil_regbank;
    localparam int NR = 16;

    function automatic logic [NR*32-1:0] mk_rv();
        logic [NR*32-1:0] v;
        v = '0;
        for (int i = 0; i < NR; i++) v[i*32 +: 32] = (i == 2) ? 32'h0 : (32'hC0DE_0000 | 32'(i));
        return v;
    endfunction

    localparam logic [NR*32-1:0] RV = mk_rv();
    localparam logic [NR-1:0]    RO = 16'h0003;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic [NR-1:0][31:0]  slv_reg;
    logic [NR-1:0][31:0]  slv_read;
    logic [NR-1:0]        wr_stb, rd_stb;
    logic [31:0]          mdl [NR];
    int                   n_chk = 0, n_err = 0;

    axil_regbank_if #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(8)) axi ();

    axil_regbank #(
        .C_S_AXI_DATA_WIDTH(32), .NUM_REGS(NR), .C_S_AXI_ADDR_WIDTH(8),
        .RO_MASK(RO), .RESET_VAL(RV)
    ) dut (
        .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n), .s_axi(axi),
        .slv_reg(slv_reg), .slv_read(slv_read), .wr_stb(wr_stb), .rd_stb(rd_stb)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_regs(input string tag);
        for (int i = 0; i < NR; i++) chk($sformatf("%s[%0d]", tag, i), slv_reg[i], mdl[i]);
    endtask

    task automatic model_reset();
        for (int i = 0; i < NR; i++) mdl[i] = RV[i*32 +: 32];
    endtask

    // Word-addressed bank: byte merge on writable in-range words, SLVERR otherwise.
    task automatic model_write(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] strb,
                               output logic [1:0] resp, output logic [NR-1:0] stb);
        int idx;
        idx = int'(addr) / 4;
        stb = '0;
        if (idx >= NR || RO[idx]) begin
            resp = 2'b10;
        end else begin
            resp = 2'b00;
            stb[idx] = 1'b1;
            for (int b = 0; b < 4; b++) if (strb[b]) mdl[idx][b*8 +: 8] = data[b*8 +: 8];
        end
    endtask

    task automatic model_read(input logic [7:0] addr, output logic [31:0] data,
                              output logic [1:0] resp, output logic [NR-1:0] stb);
        int idx;
        idx = int'(addr) / 4;
        stb = '0;
        if (idx >= NR) begin
            data = 32'h0;
            resp = 2'b10;
        end else begin
            data = RO[idx] ? slv_read[idx] : mdl[idx];
            resp = 2'b00;
            stb[idx] = 1'b1;
        end
    endtask

    task automatic axi_write(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] strb);
        int cyc;
        logic [1:0] er;
        logic [NR-1:0] es;
        @(negedge clk);
        axi.S_AXI_AWADDR = addr; axi.S_AXI_WDATA = data; axi.S_AXI_WSTRB = strb;
        axi.S_AXI_AWVALID = 1'b1; axi.S_AXI_WVALID = 1'b1;
        cyc = 0;
        while (!(axi.S_AXI_AWREADY && axi.S_AXI_WREADY) && cyc < 20) begin @(negedge clk); cyc++; end
        chk("wr_ready", axi.S_AXI_AWREADY && axi.S_AXI_WREADY, 1);
        @(negedge clk);
        axi.S_AXI_AWVALID = 1'b0; axi.S_AXI_WVALID = 1'b0;
        cyc = 1;
        while (!axi.S_AXI_BVALID && cyc < 20) begin @(negedge clk); cyc++; end
        chk("wr_latency", cyc, 2);
        model_write(addr, data, strb, er, es);
        chk("wr_bresp", axi.S_AXI_BRESP, er);
        chk("wr_stb", wr_stb, es);
        chk_regs("wr_regs");
        @(negedge clk);
        chk("wr_stb_clr", wr_stb, 0);
        chk("wr_bvalid_clr", axi.S_AXI_BVALID, 0);
    endtask

    task automatic axi_read(input logic [7:0] addr, input int hold);
        int cyc;
        logic [31:0] ed;
        logic [1:0] er;
        logic [NR-1:0] es;
        @(negedge clk);
        axi.S_AXI_ARADDR = addr; axi.S_AXI_ARVALID = 1'b1;
        cyc = 0;
        while (!axi.S_AXI_ARREADY && cyc < 20) begin @(negedge clk); cyc++; end
        chk("rd_arready", axi.S_AXI_ARREADY, 1);
        model_read(addr, ed, er, es);
        @(negedge clk);
        axi.S_AXI_ARVALID = 1'b0;
        chk("rd_rvalid", axi.S_AXI_RVALID, 1);
        chk("rd_rdata", axi.S_AXI_RDATA, ed);
        chk("rd_rresp", axi.S_AXI_RRESP, er);
        chk("rd_stb", rd_stb, es);
        slv_read = ~slv_read;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk("rd_hold_valid", axi.S_AXI_RVALID, 1);
            chk("rd_hold_data", axi.S_AXI_RDATA, ed);
            chk("rd_hold_stb", rd_stb, 0);
        end
        axi.S_AXI_RREADY = 1'b1;
        @(negedge clk);
        axi.S_AXI_RREADY = 1'b0;
        chk("rd_rvalid_clr", axi.S_AXI_RVALID, 0);
        chk("rd_stb_clr", rd_stb, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] d1, d2, old6, d6, dr;
        logic [1:0]  er;
        logic [NR-1:0] es;
        axi.S_AXI_AWADDR = '0; axi.S_AXI_AWPROT = '0; axi.S_AXI_AWVALID = 1'b0;
        axi.S_AXI_WDATA = '0; axi.S_AXI_WSTRB = '0; axi.S_AXI_WVALID = 1'b0;
        axi.S_AXI_BREADY = 1'b1;
        axi.S_AXI_ARADDR = '0; axi.S_AXI_ARPROT = '0; axi.S_AXI_ARVALID = 1'b0;
        axi.S_AXI_RREADY = 1'b0;
        slv_read = '0;
        model_reset();

        repeat (3) @(negedge clk);
        chk("rst_awready", axi.S_AXI_AWREADY, 0);
        chk("rst_arready", axi.S_AXI_ARREADY, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk_regs("rst_regs");
        chk("rel_awready", axi.S_AXI_AWREADY, 1);
        chk("rel_wready", axi.S_AXI_WREADY, 1);
        chk("rel_arready", axi.S_AXI_ARREADY, 1);
        chk("rel_bvalid", axi.S_AXI_BVALID, 0);
        chk("rel_rvalid", axi.S_AXI_RVALID, 0);

        axi_write(8'h08, 32'hA5A5_A5A5, 4'b0101);
        chk("a5_reg2", slv_reg[2], 32'h00A5_00A5);

        // W three cycles ahead of AW, with the response held off.
        d1 = 32'h1111_2222; d2 = 32'h3333_4444;
        axi.S_AXI_BREADY = 1'b0;
        @(negedge clk);
        axi.S_AXI_WDATA = d1; axi.S_AXI_WSTRB = 4'hF; axi.S_AXI_WVALID = 1'b1;
        chk("early_w_ready", axi.S_AXI_WREADY, 1);
        @(negedge clk);
        axi.S_AXI_WVALID = 1'b0;
        chk("early_w_held", axi.S_AXI_WREADY, 0);
        repeat (2) @(negedge clk);
        chk("early_no_b", axi.S_AXI_BVALID, 0);
        @(negedge clk);
        axi.S_AXI_AWADDR = 8'h0C; axi.S_AXI_AWVALID = 1'b1;
        chk("late_aw_ready", axi.S_AXI_AWREADY, 1);
        @(negedge clk);
        axi.S_AXI_AWVALID = 1'b0;
        @(negedge clk);
        model_write(8'h0C, d1, 4'hF, er, es);
        chk("stall_b1_valid", axi.S_AXI_BVALID, 1);
        chk("stall_b1_stb", wr_stb, es);
        chk("stall_b1_reg3", slv_reg[3], d1);
        axi.S_AXI_AWADDR = 8'h10; axi.S_AXI_WDATA = d2; axi.S_AXI_WSTRB = 4'hF;
        axi.S_AXI_AWVALID = 1'b1; axi.S_AXI_WVALID = 1'b1;
        chk("stall_w2_aw_ready", axi.S_AXI_AWREADY, 1);
        @(negedge clk);
        axi.S_AXI_AWVALID = 1'b0; axi.S_AXI_WVALID = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("stall_awready", axi.S_AXI_AWREADY, 0);
            chk("stall_wready", axi.S_AXI_WREADY, 0);
            chk("stall_bvalid", axi.S_AXI_BVALID, 1);
            chk("stall_reg4", slv_reg[4], mdl[4]);
            chk("stall_stb", wr_stb, 0);
            if (k < 2) @(negedge clk);
        end
        axi.S_AXI_BREADY = 1'b1;
        @(negedge clk);
        model_write(8'h10, d2, 4'hF, er, es);
        chk("stall_b2_valid", axi.S_AXI_BVALID, 1);
        chk("stall_b2_stb", wr_stb, es);
        chk("stall_b2_reg4", slv_reg[4], d2);
        @(negedge clk);
        chk("stall_b2_clr", axi.S_AXI_BVALID, 0);

        slv_read[0] = 32'hDEAD_BEEF;
        axi_read(8'h00, 0);
        axi_write(8'h00, 32'h1234_5678, 4'hF);
        axi_read(8'h40, 1);

        // AR handshake on the same edge the write commits sees the old word.
        old6 = mdl[6]; d6 = 32'h6666_0006;
        @(negedge clk);
        axi.S_AXI_AWADDR = 8'h18; axi.S_AXI_WDATA = d6; axi.S_AXI_WSTRB = 4'hF;
        axi.S_AXI_AWVALID = 1'b1; axi.S_AXI_WVALID = 1'b1;
        @(negedge clk);
        axi.S_AXI_AWVALID = 1'b0; axi.S_AXI_WVALID = 1'b0;
        axi.S_AXI_ARADDR = 8'h18; axi.S_AXI_ARVALID = 1'b1;
        @(negedge clk);
        axi.S_AXI_ARVALID = 1'b0;
        chk("coll_rvalid", axi.S_AXI_RVALID, 1);
        chk("coll_old", axi.S_AXI_RDATA, old6);
        chk("coll_bvalid", axi.S_AXI_BVALID, 1);
        model_write(8'h18, d6, 4'hF, er, es);
        axi.S_AXI_RREADY = 1'b1;
        @(negedge clk);
        axi.S_AXI_RREADY = 1'b0;
        axi_read(8'h18, 0);

        for (int it = 0; it < 60; it++) begin
            slv_read = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom,
                        $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            if ($urandom_range(0, 1) == 0)
                axi_write(8'($urandom_range(0, 127)), $urandom, 4'($urandom));
            else
                axi_read(8'($urandom_range(0, 127)), int'($urandom_range(0, 3)));
        end

        // Reset with AW held and no W yet; the pending AW must be dropped.
        @(negedge clk);
        axi.S_AXI_AWADDR = 8'h14; axi.S_AXI_AWVALID = 1'b1;
        @(negedge clk);
        axi.S_AXI_AWVALID = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        chk("arst_awready", axi.S_AXI_AWREADY, 0);
        chk("arst_wready", axi.S_AXI_WREADY, 0);
        chk("arst_arready", axi.S_AXI_ARREADY, 0);
        chk("arst_bvalid", axi.S_AXI_BVALID, 0);
        chk("arst_rvalid", axi.S_AXI_RVALID, 0);
        chk("arst_rdata", axi.S_AXI_RDATA, 0);
        chk("arst_bresp", axi.S_AXI_BRESP, 0);
        chk("arst_rresp", axi.S_AXI_RRESP, 0);
        chk("arst_wr_stb", wr_stb, 0);
        chk("arst_rd_stb", rd_stb, 0);
        chk_regs("arst_regs");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        dr = 32'h5A5A_0505;
        axi.S_AXI_WDATA = dr; axi.S_AXI_WSTRB = 4'hF; axi.S_AXI_WVALID = 1'b1;
        chk("lone_w_ready", axi.S_AXI_WREADY, 1);
        @(negedge clk);
        axi.S_AXI_WVALID = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk("lone_w_no_b", axi.S_AXI_BVALID, 0);
            chk("lone_w_no_stb", wr_stb, 0);
            @(negedge clk);
        end
        chk_regs("lone_w_regs");
        axi.S_AXI_AWADDR = 8'h14; axi.S_AXI_AWVALID = 1'b1;
        chk("new_aw_ready", axi.S_AXI_AWREADY, 1);
        @(negedge clk);
        axi.S_AXI_AWVALID = 1'b0;
        @(negedge clk);
        model_write(8'h14, dr, 4'hF, er, es);
        chk("new_aw_bvalid", axi.S_AXI_BVALID, 1);
        chk("new_aw_bresp", axi.S_AXI_BRESP, er);
        chk("new_aw_stb", wr_stb, es);
        chk_regs("new_aw_regs");
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end
endmodule
